// File: rtl/seg_scan_ctrl_pkg.sv
// Shared display constants for the multiplexed seven-segment scan controller:
// register map offsets, CTRL bit positions and the fixed segment patterns.
package seg_scan_ctrl_pkg;

    localparam logic [31:0] OFS_CTRL  = 32'h0000_0000;
    localparam logic [31:0] OFS_DATA  = 32'h0000_0004;
    localparam logic [31:0] OFS_BLINK = 32'h0000_0008;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_SIGNED = 1;
    localparam int CTRL_LZB    = 2;
    localparam int CTRL_W      = 3;

    // Active-low {dp,a,b,c,d,e,f,g}: all segments off, and only the g bar lit.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hFE;

endpackage

// File: rtl/seg_scan_ctrl_hex_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit order {dp,a,b,c,d,e,f,g}.
module seg_hex_decoder (
    input  logic [3:0] nibble,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = 8'hFF;
        case (nibble)
            4'h0: pattern = 8'h81;
            4'h1: pattern = 8'hCF;
            4'h2: pattern = 8'h92;
            4'h3: pattern = 8'h86;
            4'h4: pattern = 8'hCC;
            4'h5: pattern = 8'hA4;
            4'h6: pattern = 8'hA0;
            4'h7: pattern = 8'h8F;
            4'h8: pattern = 8'h80;
            4'h9: pattern = 8'h84;
            4'hA: pattern = 8'h88;
            4'hB: pattern = 8'hE0;
            4'hC: pattern = 8'hB1;
            4'hD: pattern = 8'hC2;
            4'hE: pattern = 8'hB0;
            4'hF: pattern = 8'hB8;
            default: pattern = 8'hFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// MMIO-programmed seven-segment scan controller: several digit groups share one
// select line, with signed display, leading-zero blanking and per-digit blink.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int          NUM_GROUPS       = 2,
    parameter int          DIGITS_PER_GROUP = 4,
    parameter int          SCAN_PRESET      = 100000,
    parameter int          BLINK_PRESET     = 25,
    parameter logic [31:0] BASE_ADDR        = 32'h0000_7f30
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   addr,
    input  logic [31:0]                   wdata,
    input  logic                          we,
    output logic [31:0]                   rdata,
    output logic [NUM_GROUPS*8-1:0]       seg,
    output logic [DIGITS_PER_GROUP-1:0]   sel,
    output logic [7:0]                    sign_seg
);

    localparam int NUM_DIGITS = NUM_GROUPS * DIGITS_PER_GROUP;
    localparam int W          = 4 * NUM_DIGITS;
    localparam int SLOT_W     = (DIGITS_PER_GROUP > 1) ? $clog2(DIGITS_PER_GROUP) : 1;
    localparam int SCAN_W     = (SCAN_PRESET > 0) ? $clog2(SCAN_PRESET + 1) : 1;
    localparam int BLK_W      = (BLINK_PRESET > 0) ? $clog2(BLINK_PRESET + 1) : 1;
    localparam logic [DIGITS_PER_GROUP-1:0] SEL_MSB =
        DIGITS_PER_GROUP'(1) << (DIGITS_PER_GROUP - 1);

    localparam logic [31:0] ADDR_CTRL  = BASE_ADDR + OFS_CTRL;
    localparam logic [31:0] ADDR_DATA  = BASE_ADDR + OFS_DATA;
    localparam logic [31:0] ADDR_BLINK = BASE_ADDR + OFS_BLINK;

    logic [CTRL_W-1:0]     ctrl;
    logic [W-1:0]          data;
    logic [NUM_DIGITS-1:0] blink;

    logic [SCAN_W-1:0]     scan_cnt;
    logic [SLOT_W-1:0]     slot;
    logic [BLK_W-1:0]      blk_cnt;
    logic                  blk_on;

    // Register file
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl  <= CTRL_W'(1);
            data  <= '0;
            blink <= '0;
        end else if (we) begin
            if (addr == ADDR_CTRL)  ctrl  <= wdata[CTRL_W-1:0];
            if (addr == ADDR_DATA)  data  <= wdata[W-1:0];
            if (addr == ADDR_BLINK) blink <= wdata[NUM_DIGITS-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (addr == ADDR_CTRL)       rdata[CTRL_W-1:0]     = ctrl;
        else if (addr == ADDR_DATA)  rdata[W-1:0]          = data;
        else if (addr == ADDR_BLINK) rdata[NUM_DIGITS-1:0] = blink;
    end

    // Scan timing runs free of register writes; only reset restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= SCAN_W'(SCAN_PRESET);
            slot     <= '0;
            blk_cnt  <= '0;
            blk_on   <= 1'b1;
        end else if (scan_cnt == '0) begin
            scan_cnt <= SCAN_W'(SCAN_PRESET);
            if (slot == SLOT_W'(DIGITS_PER_GROUP - 1)) begin
                slot <= '0;
                if (blk_cnt == BLK_W'(BLINK_PRESET)) begin
                    blk_cnt <= '0;
                    blk_on  <= ~blk_on;
                end else begin
                    blk_cnt <= blk_cnt + 1'b1;
                end
            end else begin
                slot <= slot + 1'b1;
            end
        end else begin
            scan_cnt <= scan_cnt - 1'b1;
        end
    end

    logic                  neg;
    logic [W-1:0]          disp;
    logic [NUM_DIGITS-1:0] digit_off;

    // Most-negative value negates to itself, so it shows its raw bits.
    assign neg  = ctrl[CTRL_SIGNED] & data[W-1];
    assign disp = neg ? (~data + W'(1)) : data;

    assign digit_off[0] = ~ctrl[CTRL_EN] | (~blk_on & blink[0]);
    for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_off
        assign digit_off[i] = ~ctrl[CTRL_EN] | (~blk_on & blink[i]) |
                              (ctrl[CTRL_LZB] & ~|disp[W-1:4*i]);
    end

    logic [NUM_GROUPS-1:0][7:0] seg_nxt;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        logic [3:0] nib;
        logic       blank;
        logic [7:0] hex_pat;

        always_comb begin
            nib   = '0;
            blank = 1'b0;
            for (int k = 0; k < DIGITS_PER_GROUP; k++) begin
                if (slot == SLOT_W'(k)) begin
                    nib   = disp[4*(g*DIGITS_PER_GROUP + DIGITS_PER_GROUP-1-k) +: 4];
                    blank = digit_off[g*DIGITS_PER_GROUP + DIGITS_PER_GROUP-1-k];
                end
            end
        end

        seg_hex_decoder u_dec (
            .nibble  (nib),
            .pattern (hex_pat)
        );

        assign seg_nxt[g] = blank ? SEG_BLANK : hex_pat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg      <= {NUM_GROUPS{SEG_BLANK}};
            sel      <= SEL_MSB;
            sign_seg <= SEG_BLANK;
        end else begin
            seg      <= seg_nxt;
            sel      <= SEL_MSB >> slot;
            sign_seg <= (ctrl[CTRL_EN] & neg) ? SEG_MINUS : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a cycle-count based display model
// checked every cycle, plus literal expectations for key display frames.
module tb_seg_scan_ctrl;

    localparam int          NG   = 2;
    localparam int          D    = 4;
    localparam int          P    = 3;
    localparam int          BP   = 1;
    localparam logic [31:0] BASE = 32'h0000_7f30;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        we;
    logic [15:0] seg;
    logic [3:0]  sel;
    logic [7:0]  sign_seg;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_ctrl, m_data, m_blink;
    int unsigned n;
    logic [15:0] exp_seg;
    logic [3:0]  exp_sel;
    logic [7:0]  exp_sign;

    seg_scan_ctrl #(
        .NUM_GROUPS       (NG),
        .DIGITS_PER_GROUP (D),
        .SCAN_PRESET      (P),
        .BLINK_PRESET     (BP),
        .BASE_ADDR        (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .rdata    (rdata),
        .seg      (seg),
        .sel      (sel),
        .sign_seg (sign_seg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 8'h81; 4'h1: return 8'hCF; 4'h2: return 8'h92; 4'h3: return 8'h86;
            4'h4: return 8'hCC; 4'h5: return 8'hA4; 4'h6: return 8'hA0; 4'h7: return 8'h8F;
            4'h8: return 8'h80; 4'h9: return 8'h84; 4'hA: return 8'h88; 4'hB: return 8'hE0;
            4'hC: return 8'hB1; 4'hD: return 8'hC2; 4'hE: return 8'hB0; default: return 8'hB8;
        endcase
    endfunction

    // Display frame from elapsed edges since reset and the register contents.
    function automatic logic [15:0] model_seg(input int unsigned cyc, input logic [31:0] c,
                                              input logic [31:0] d, input logic [31:0] b);
        int unsigned slot, rounds;
        bit          on;
        logic [31:0] v;
        logic [15:0] r;
        slot   = (cyc / (P + 1)) % D;
        rounds = cyc / ((P + 1) * D);
        on     = ((rounds / (BP + 1)) % 2) == 0;
        v      = (c[1] && d[31]) ? (32'd0 - d) : d;
        r      = '0;
        for (int g = 0; g < NG; g++) begin
            int          i;
            logic [31:0] up;
            i  = g * D + D - 1 - int'(slot);
            up = v >> (4 * i);
            if (!c[0] || (c[2] && i != 0 && up == 0) || (!on && b[i]))
                r[8*g +: 8] = 8'hFF;
            else
                r[8*g +: 8] = hex7(up[3:0]);
        end
        return r;
    endfunction

    function automatic logic [3:0] model_sel(input int unsigned cyc);
        logic [3:0] top;
        top = 4'b1000;
        return top >> ((cyc / (P + 1)) % D);
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] a, input logic [31:0] c,
                                                input logic [31:0] d, input logic [31:0] b);
        if (a == BASE)      return c;
        if (a == BASE + 4)  return d;
        if (a == BASE + 8)  return b;
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ctrl   <= 32'd1;
            m_data   <= 32'd0;
            m_blink  <= 32'd0;
            n        <= 0;
            exp_seg  <= 16'hFFFF;
            exp_sel  <= 4'b1000;
            exp_sign <= 8'hFF;
        end else begin
            exp_seg  <= model_seg(n, m_ctrl, m_data, m_blink);
            exp_sel  <= model_sel(n);
            exp_sign <= (m_ctrl[0] && m_ctrl[1] && m_data[31]) ? 8'hFE : 8'hFF;
            n        <= n + 1;
            if (we) begin
                if (addr == BASE)     m_ctrl  <= wdata & 32'h7;
                if (addr == BASE + 4) m_data  <= wdata;
                if (addr == BASE + 8) m_blink <= wdata & 32'hFF;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(negedge clk);
            check("seg",      {16'd0, seg},      {16'd0, exp_seg});
            check("sel",      {28'd0, sel},      {28'd0, exp_sel});
            check("sign_seg", {24'd0, sign_seg}, {24'd0, exp_sign});
            check("rdata",    rdata, model_rdata(addr, m_ctrl, m_data, m_blink));
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick(1);
        we = 1'b0; addr = BASE;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1 v = rdata;
    endtask

    task automatic wait_sel(input logic [3:0] t, output int cnt);
        cnt = 0;
        while (sel !== t && cnt < 64) begin
            tick(1);
            cnt++;
        end
        if (sel !== t) check("wait_sel_timeout", {28'd0, sel}, {28'd0, t});
    endtask

    initial begin
        int          c;
        logic [31:0] v;
        logic [7:0]  bv [4];
        reset = 1'b1; we = 1'b0; addr = BASE; wdata = 32'd0;
        tick(2);
        check("rst_seg", {16'd0, seg}, 32'h0000_FFFF);
        check("rst_sel", {28'd0, sel}, 32'h8);
        check("rst_sign", {24'd0, sign_seg}, 32'hFF);
        check("rst_ctrl", rdata, 32'd1);
        rd(BASE + 4, v); check("rst_data", v, 32'd0);
        addr = BASE;
        reset = 1'b0;
        tick(3);

        wr(BASE + 4, 32'h1234_ABCD);
        tick(2);
        wait_sel(4'b1000, c); check("hex_s0", {16'd0, seg}, 32'h0000_CF88);
        wait_sel(4'b0100, c); check("hex_s1", {16'd0, seg}, 32'h0000_92E0);
        wait_sel(4'b0010, c); check("slot_len", c, 4);
        check("hex_s2", {16'd0, seg}, 32'h0000_86B1);
        wait_sel(4'b0001, c); check("hex_s3", {16'd0, seg}, 32'h0000_CCC2);

        wr(BASE, 32'd3);
        wr(BASE + 4, 32'hFFFF_FFFF);
        tick(2);
        check("neg_sign", {24'd0, sign_seg}, 32'hFE);
        wait_sel(4'b0001, c); check("neg_d0", {16'd0, seg}, 32'h0000_81CF);
        wait_sel(4'b1000, c); check("neg_d3", {16'd0, seg}, 32'h0000_8181);

        wr(BASE, 32'hFFFF_FFFD);
        rd(BASE, v); check("ctrl_mask", v, 32'd5);
        wr(BASE + 4, 32'h0000_0042);
        tick(2);
        check("lzb_sign", {24'd0, sign_seg}, 32'hFF);
        wait_sel(4'b1000, c); check("lzb_s0", {16'd0, seg}, 32'h0000_FFFF);
        wait_sel(4'b0010, c); check("lzb_s2", {16'd0, seg}, 32'h0000_FFCC);
        wait_sel(4'b0001, c); check("lzb_s3", {16'd0, seg}, 32'h0000_FF92);

        wr(BASE, 32'd1);
        wr(BASE + 8, 32'h0000_0001);
        rd(BASE + 8, v); check("blink_rd", v, 32'd1);
        addr = BASE;
        for (int r = 0; r < 4; r++) begin
            wait_sel(4'b0100, c);
            wait_sel(4'b0001, c);
            bv[r] = seg[7:0];
            check("blink_val", {31'd0, (bv[r] == 8'h92 || bv[r] == 8'hFF)}, 32'd1);
        end
        check("blink_ph02", {31'd0, bv[0] != bv[2]}, 32'd1);
        check("blink_ph13", {31'd0, bv[1] != bv[3]}, 32'd1);

        // Write landing on the slot-advance edge must not shift the scan.
        wait_sel(4'b0010, c);
        tick(3);
        wr(BASE + 4, 32'h8765_4321);
        check("coinc_sel", {28'd0, sel}, 32'h1);
        wait_sel(4'b1000, c); check("coinc_len", c, 4);
        check("coinc_seg", {16'd0, seg}, 32'h0000_80CC);

        wr(BASE, 32'd7);
        tick(20);
        wr(BASE + 12, 32'hFFFF_FFFF);
        rd(BASE + 12, v); check("bad_rd", v, 32'd0);
        rd(BASE, v);      check("bad_ctrl", v, 32'd7);
        rd(BASE + 4, v);  check("bad_data", v, 32'h8765_4321);
        rd(BASE + 8, v);  check("bad_blink", v, 32'd1);
        addr = BASE;

        wait_sel(4'b0010, c);
        tick(1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_sel", {28'd0, sel}, 32'h8);
        check("mid_rst_seg", {16'd0, seg}, 32'h0000_FFFF);
        check("mid_rst_ctrl", rdata, 32'd1);
        tick(2);
        reset = 1'b0;
        tick(1);
        check("post_rst_seg", {16'd0, seg}, 32'h0000_8181);
        tick(24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
